imem_sync: RTL

IMEM_SYNC -- requirements
Module: imem_sync

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/imem_array.sv | 33 +++
 rtl/imem_sync.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the synchronous instruction-memory fetch port.
package fetch_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned FAULT_W = 2;
   localparam int unsigned CNT_W   = 3;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [FAULT_W-1:0] {
      FAULT_OK       = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_RANGE    = 2'b10
   } fault_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Offset-based range test stays correct when addr < base (offset wraps high).
   function automatic fault_e fault_of(input logic [XLEN-1:0] addr,
                                       input logic [XLEN-1:0] base,
                                       input logic [XLEN-1:0] span);
      logic [XLEN-1:0] off;
      off = addr - base;
      if (addr[1:0] != 2'b00) return FAULT_MISALIGN;
      if (off >= span)        return FAULT_RANGE;
      return FAULT_OK;
   endfunction

endpackage

// File: rtl/imem_array.sv
// Read-only DEPTH x 32 instruction store with a registered synchronous read port.
module imem_array
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter string       INIT_FILE = "imem.hex",
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rd_en_i,
   input  logic            clr_i,
   input  logic [AW-1:0]   rd_idx_i,
   output logic [XLEN-1:0] rd_data_o
);

   logic [XLEN-1:0] mem [DEPTH];
   logic [XLEN-1:0] rd_data_q;

   // clr_i returns a NOP without touching the array (faulted or cancelled fetch).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= NOP_INSTR;
      end else if (clr_i) begin
         rd_data_q <= NOP_INSTR;
      end else if (rd_en_i) begin
         rd_data_q <= mem[rd_idx_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_sync.sv
// Instruction fetch front end: request/response handshake, fault decode,
// programmable wait-state counter and flush, in front of imem_array.
module imem_sync
   import fetch_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 1,
   parameter string       INIT_FILE = "imem.hex"
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [XLEN-1:0]   req_addr,
   input  logic              flush,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_instr,
   output logic [FAULT_W-1:0] resp_fault
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned SPAN = 4 * DEPTH;
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             resp_valid_q, resp_valid_d;
   fault_e           resp_fault_q, resp_fault_d;

   logic             accept_c;
   logic             rd_en_c;
   logic             clr_c;
   fault_e           fault_c;
   logic [AW-1:0]    rd_idx_c;

   assign req_ready = !flush && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
   assign accept_c  = req_valid && req_ready;
   assign fault_c   = fault_of(req_addr, BASE_ADDR, 32'(SPAN));
   assign rd_idx_c  = AW'((req_addr - BASE_ADDR) >> 2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= FAULT_OK;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
      end
   end

   // A flush wins over everything, including a same-cycle response handshake.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      resp_valid_d = resp_valid_q;
      resp_fault_d = resp_fault_q;
      rd_en_c      = 1'b0;
      clr_c        = 1'b0;
      if (flush) begin
         state_d      = IDLE;
         cnt_d        = '0;
         resp_valid_d = 1'b0;
         clr_c        = 1'b1;
      end else if (accept_c) begin
         rd_en_c      = (fault_c == FAULT_OK);
         clr_c        = (fault_c != FAULT_OK);
         resp_fault_d = fault_c;
         if (LATENCY == 0) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end else begin
            state_d      = WAIT;
            cnt_d        = CNT_INIT;
            resp_valid_d = 1'b0;
         end
      end else begin
         case (state_q)
            WAIT: begin
               if (cnt_q == '0) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_d      = IDLE;
                  resp_valid_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   imem_array #(
      .DEPTH    (DEPTH),
      .INIT_FILE(INIT_FILE)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en_i  (rd_en_c),
      .clr_i    (clr_c),
      .rd_idx_i (rd_idx_c),
      .rd_data_o(resp_instr)
   );

   assign resp_valid = resp_valid_q;
   assign resp_fault = resp_fault_q;

endmodule
